// File: rtl/nn_reg_bank.sv
// Multi-channel register bank with addressed, broadcast and serial-shift writes.
// Tracks per-channel valid bits and a saturating shift counter with a load-complete pulse.
module nn_reg_bank #(
   parameter int unsigned WIDTH    = 14,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned ADDR_W   = 2
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic                      clr,
   input  logic                      wr_en,
   input  logic [1:0]                mode,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   output logic [CHANNELS*WIDTH-1:0] o,
   output logic [CHANNELS-1:0]       valid,
   output logic                      all_valid,
   output logic [ADDR_W:0]           shift_cnt,
   output logic                      load_done,
   output logic                      addr_err
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHANNELS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHANNELS - 1);

   localparam logic [1:0] MODE_ADDR  = 2'b01;
   localparam logic [1:0] MODE_BCAST = 2'b10;
   localparam logic [1:0] MODE_SHIFT = 2'b11;

   logic [WIDTH-1:0]    r_ch [CHANNELS];
   logic [CHANNELS-1:0] r_valid;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_load_done;
   logic                r_addr_err;
   logic                w_addr_ok;

   assign w_addr_ok = (32'(wr_addr) < CHANNELS);

   // Single state process; Rst and clr share the same clearing effect.
   always_ff @(posedge Clk) begin
      r_load_done <= 1'b0;
      r_addr_err  <= 1'b0;
      if (Rst || clr) begin
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            r_ch[k] <= '0;
         end
         r_valid <= '0;
         r_cnt   <= '0;
      end else if (wr_en) begin
         case (mode)
            MODE_ADDR: begin
               if (w_addr_ok) begin
                  for (int unsigned k = 0; k < CHANNELS; k++) begin
                     if (ADDR_W'(k) == wr_addr) begin
                        r_ch[k]    <= wr_data;
                        r_valid[k] <= 1'b1;
                     end
                  end
               end else begin
                  r_addr_err <= 1'b1;
               end
            end
            MODE_BCAST: begin
               for (int unsigned k = 0; k < CHANNELS; k++) begin
                  r_ch[k] <= wr_data;
               end
               r_valid <= '1;
            end
            MODE_SHIFT: begin
               r_ch[0] <= wr_data;
               for (int unsigned k = 1; k < CHANNELS; k++) begin
                  r_ch[k] <= r_ch[k-1];
               end
               r_valid <= {r_valid[CHANNELS-2:0], 1'b1};
               // Counter saturates; the pulse fires only on the final step.
               if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_LAST) begin
                     r_load_done <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_flat
      assign o[g*WIDTH +: WIDTH] = r_ch[g];
   end

   assign valid     = r_valid;
   assign all_valid = &r_valid;
   assign shift_cnt = r_cnt;
   assign load_done = r_load_done;
   assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_nn_reg_bank.sv
// Self-checking bench for nn_reg_bank: directed literal checks plus randomized traffic
// compared each cycle against a behavioural model, on a 4-channel and a 3-channel instance.
module tb_nn_reg_bank;

   logic        Clk = 1'b0;
   logic        Rst, clr, wr_en;
   logic [1:0]  mode;
   logic [1:0]  wr_addr;
   logic [13:0] wr_data;

   logic [55:0] o4;
   logic [3:0]  valid4;
   logic        all_valid4, load_done4, addr_err4;
   logic [2:0]  cnt4;

   logic [41:0] o3;
   logic [2:0]  valid3;
   logic        all_valid3, load_done3, addr_err3;
   logic [2:0]  cnt3;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   always #5 Clk = ~Clk;

   nn_reg_bank #(.WIDTH(14), .CHANNELS(4), .ADDR_W(2)) u_dut4 (
      .Clk(Clk), .Rst(Rst), .clr(clr), .wr_en(wr_en), .mode(mode),
      .wr_addr(wr_addr), .wr_data(wr_data), .o(o4), .valid(valid4),
      .all_valid(all_valid4), .shift_cnt(cnt4), .load_done(load_done4),
      .addr_err(addr_err4));

   nn_reg_bank #(.WIDTH(14), .CHANNELS(3), .ADDR_W(2)) u_dut3 (
      .Clk(Clk), .Rst(Rst), .clr(clr), .wr_en(wr_en), .mode(mode),
      .wr_addr(wr_addr), .wr_data(wr_data), .o(o3), .valid(valid3),
      .all_valid(all_valid3), .shift_cnt(cnt3), .load_done(load_done3),
      .addr_err(addr_err3));

   // Behavioural model: index 0 models 4 channels, index 1 models 3 channels.
   logic [13:0] m_ch [2][4];
   bit          m_val [2][4];
   int          m_cnt [2];
   bit          m_ld  [2];
   bit          m_ae  [2];
   int          nch   [2] = '{4, 3};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_step(input int i);
      int a;
      m_ld[i] = 1'b0;
      m_ae[i] = 1'b0;
      if (Rst || clr) begin
         for (int k = 0; k < 4; k++) begin m_ch[i][k] = '0; m_val[i][k] = 1'b0; end
         m_cnt[i] = 0;
      end else if (wr_en) begin
         a = int'(wr_addr);
         if (mode == 2'b01) begin
            if (a < nch[i]) begin m_ch[i][a] = wr_data; m_val[i][a] = 1'b1; end
            else m_ae[i] = 1'b1;
         end else if (mode == 2'b10) begin
            for (int k = 0; k < nch[i]; k++) begin m_ch[i][k] = wr_data; m_val[i][k] = 1'b1; end
         end else if (mode == 2'b11) begin
            for (int k = nch[i] - 1; k > 0; k--) begin
               m_ch[i][k]  = m_ch[i][k-1];
               m_val[i][k] = m_val[i][k-1];
            end
            m_ch[i][0]  = wr_data;
            m_val[i][0] = 1'b1;
            if (m_cnt[i] < nch[i]) begin
               m_cnt[i]++;
               if (m_cnt[i] == nch[i]) m_ld[i] = 1'b1;
            end
         end
      end
   endtask

   always @(posedge Clk) begin
      model_step(0);
      model_step(1);
   end

   function automatic logic [63:0] exp_o(input int i);
      logic [63:0] r = '0;
      for (int k = 0; k < nch[i]; k++) r[k*14 +: 14] = m_ch[i][k];
      return r;
   endfunction

   function automatic logic [63:0] exp_v(input int i);
      logic [63:0] r = '0;
      for (int k = 0; k < nch[i]; k++) r[k] = m_val[i][k];
      return r;
   endfunction

   function automatic logic exp_all(input int i);
      logic r = 1'b1;
      for (int k = 0; k < nch[i]; k++) r = r & m_val[i][k];
      return r;
   endfunction

   // Compare process: every cycle, away from the active edge.
   always @(negedge Clk) begin
      if (chk_en) begin
         check("o4",      64'(o4),         exp_o(0));
         check("valid4",  64'(valid4),     exp_v(0));
         check("all4",    64'(all_valid4), 64'(exp_all(0)));
         check("cnt4",    64'(cnt4),       64'(m_cnt[0]));
         check("ld4",     64'(load_done4), 64'(m_ld[0]));
         check("ae4",     64'(addr_err4),  64'(m_ae[0]));
         check("o3",      64'(o3),         exp_o(1));
         check("valid3",  64'(valid3),     exp_v(1));
         check("all3",    64'(all_valid3), 64'(exp_all(1)));
         check("cnt3",    64'(cnt3),       64'(m_cnt[1]));
         check("ld3",     64'(load_done3), 64'(m_ld[1]));
         check("ae3",     64'(addr_err3),  64'(m_ae[1]));
      end
   end

   task automatic tick(input logic rst_i, input logic clr_i, input logic we_i,
                       input logic [1:0] mode_i, input logic [1:0] addr_i, input logic [13:0] data_i);
      Rst = rst_i; clr = clr_i; wr_en = we_i; mode = mode_i; wr_addr = addr_i; wr_data = data_i;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      logic [55:0] snap;
      tick(1'b1, 1'b0, 1'b1, 2'b10, 2'd0, 14'h1234);
      chk_en = 1'b1;
      check("rst_o",     64'(o4),         64'(0));
      check("rst_valid", 64'(valid4),     64'(0));
      check("rst_cnt",   64'(cnt4),       64'(0));
      check("rst_ld",    64'(load_done4), 64'(0));

      tick(1'b0, 1'b0, 1'b1, 2'b01, 2'd2, 14'h0011);
      check("addr2_data",  64'(o4[41:28]),  64'(14'h0011));
      check("addr2_valid", 64'(valid4),     64'(4'b0100));
      check("addr2_all",   64'(all_valid4), 64'(0));
      tick(1'b0, 1'b0, 1'b1, 2'b01, 2'd0, 14'h0100);
      tick(1'b0, 1'b0, 1'b1, 2'b01, 2'd1, 14'h0200);
      check("dut3_pre_err_valid", 64'(valid3), 64'(3'b111));
      snap = 56'(o3);
      tick(1'b0, 1'b0, 1'b1, 2'b01, 2'd3, 14'h0300);
      check("addr_all4",   64'(all_valid4), 64'(1));
      check("addr_err3",   64'(addr_err3),  64'(1));
      check("addr_err4",   64'(addr_err4),  64'(0));
      check("err3_o_same", 64'(o3),         64'(snap));
      tick(1'b0, 1'b0, 1'b0, 2'b01, 2'd3, 14'h0300);
      check("addr_err3_pulse", 64'(addr_err3), 64'(0));

      tick(1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 14'h0);
      tick(1'b0, 1'b0, 1'b1, 2'b11, 2'd0, 14'd1);
      tick(1'b0, 1'b0, 1'b1, 2'b11, 2'd0, 14'd2);
      tick(1'b0, 1'b0, 1'b1, 2'b11, 2'd0, 14'd3);
      check("shift3_ld4", 64'(load_done4), 64'(0));
      check("shift3_ld3", 64'(load_done3), 64'(1));
      tick(1'b0, 1'b0, 1'b1, 2'b11, 2'd0, 14'd4);
      check("shift4_o",   64'(o4),         64'({14'd1, 14'd2, 14'd3, 14'd4}));
      check("shift4_cnt", 64'(cnt4),       64'(4));
      check("shift4_ld",  64'(load_done4), 64'(1));
      tick(1'b0, 1'b0, 1'b1, 2'b11, 2'd0, 14'd5);
      check("shift5_ch3", 64'(o4[55:42]),  64'(2));
      check("shift5_ld",  64'(load_done4), 64'(0));
      check("shift5_cnt", 64'(cnt4),       64'(4));

      tick(1'b0, 1'b0, 1'b1, 2'b10, 2'd0, 14'h3FFF);
      for (int c = 0; c < 10; c++) begin
         tick(1'b0, 1'b0, 1'b0, 2'b11, 2'($urandom), 14'($urandom));
         check("hold_o", 64'(o4), 64'({4{14'h3FFF}}));
      end
      tick(1'b0, 1'b1, 1'b1, 2'b11, 2'd0, 14'h0ABC);
      check("clr_o",     64'(o4),     64'(0));
      check("clr_cnt",   64'(cnt4),   64'(0));
      check("clr_valid", 64'(valid4), 64'(0));

      tick(1'b0, 1'b0, 1'b1, 2'b11, 2'd0, 14'h0009);
      tick(1'b0, 1'b0, 1'b1, 2'b11, 2'd0, 14'h0009);
      tick(1'b1, 1'b0, 1'b1, 2'b11, 2'd0, 14'h0009);
      tick(1'b0, 1'b0, 1'b1, 2'b11, 2'd0, 14'h000A);
      tick(1'b0, 1'b0, 1'b1, 2'b11, 2'd0, 14'h000B);
      tick(1'b0, 1'b0, 1'b1, 2'b11, 2'd0, 14'h000C);
      check("midrst_ld3", 64'(load_done4), 64'(0));
      tick(1'b0, 1'b0, 1'b1, 2'b11, 2'd0, 14'h000D);
      check("midrst_ld4", 64'(load_done4), 64'(1));
      check("midrst_o",   64'(o4),         64'({14'hA, 14'hB, 14'hC, 14'hD}));

      for (int c = 0; c < 3000; c++) begin
         tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom), 14'($urandom));
      end
      tick(1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 14'h0);
      @(negedge Clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/nn_reg_bank.md
Name: nn_reg_bank

Overview:
Parametrised multi-channel register bank; generalises the single 14-bit enable register used for neuron weights, inputs and accumulators. Holds CHANNELS words of WIDTH bits. Each word can be written by address, by broadcast, or by a serial shift chain. Per-channel valid tracking, a shift-load counter and a load-complete pulse let the neuron controller start computation once all operands are loaded.

Parameters:
WIDTH, 14, data width of each channel word.
CHANNELS, 4, number of channel words (2..16).
ADDR_W, 2, width of the write address; must satisfy 2**ADDR_W >= CHANNELS.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Rst  input  1  synchronous, active-high reset.
clr  input  1  synchronous clear of data, valid bits and counter.
wr_en  input  1  write/shift strobe; the mode action is taken only when high.
mode  input  2  00 HOLD, 01 ADDR, 10 BCAST, 11 SHIFT.
wr_addr  input  ADDR_W  target channel in ADDR mode.
wr_data  input  WIDTH  write data; serial input word in SHIFT mode.
o  output  CHANNELS*WIDTH  flattened contents; channel k occupies bits [k*WIDTH +: WIDTH].
valid  output  CHANNELS  per-channel written flag.
all_valid  output  1  AND of valid.
shift_cnt  output  ADDR_W+1  number of shifts since the last Rst or clr, saturating at CHANNELS.
load_done  output  1  one-cycle pulse when shift_cnt reaches CHANNELS.
addr_err  output  1  one-cycle pulse on an ADDR write with wr_addr >= CHANNELS.

Behaviour:
- Reset is synchronous and active-high. When Rst=1, on the next edge: o=0, valid=0, shift_cnt=0, load_done=0, addr_err=0. Reset wins over every other input. Reset in the middle of a shift load discards the partial load.
- Priority: Rst > clr > wr_en. clr has the same effect as Rst on every register.
- wr_en=0, or mode=HOLD: all state holds. load_done and addr_err return to 0.
- ADDR mode: ch[wr_addr] <= wr_data and valid[wr_addr] <= 1; other channels are unchanged.
- ADDR mode with wr_addr >= CHANNELS: no state change; addr_err=1 for one cycle.
- BCAST mode: every channel <= wr_data; valid <= all ones. shift_cnt is unchanged.
- SHIFT mode: ch[0] <= wr_data and ch[k] <= ch[k-1] for k >= 1; ch[CHANNELS-1] falls off the end. valid <= {valid[CHANNELS-2:0], 1}.
- SHIFT mode counter: shift_cnt increments by 1, saturating at CHANNELS. load_done=1 only on the edge where shift_cnt goes from CHANNELS-1 to CHANNELS. Further shifts after saturation keep shifting data but do not pulse load_done again.
- Latency: all outputs are registered. Written data appears on o one cycle after the strobe edge. all_valid is combinational from the valid register.
- load_done and addr_err are registered single-cycle pulses.
- ADDR and BCAST writes do not change shift_cnt. Mixing modes is legal.

Test Plan:
- Reset: assert Rst with wr_en=1, mode=BCAST, wr_data=14'h1234 -> after the edge o=0, valid=0000, shift_cnt=0, load_done=0.
- ADDR writes: write 14'h0011 to addr 2 -> bits [41:28]=14'h0011, valid=0100, all_valid=0; then addr 0,1,3 -> all_valid=1.
- ADDR error: CHANNELS=3, ADDR_W=2, addr 3 -> addr_err pulses for 1 cycle, o and valid unchanged.
- SHIFT load: shift 1,2,3,4 on consecutive cycles -> ch0=4, ch1=3, ch2=2, ch3=1. load_done high only on the cycle after the 4th shift; shift_cnt=4. A 5th shift of 5 -> ch3=2, no load_done.
- Priority and hold: clr=1 with wr_en=1, mode=SHIFT -> everything cleared, no shift taken. wr_en=0 for 10 cycles -> o stable.
- Reset mid-load: 2 shifts, then Rst, then 4 shifts -> load_done after the 4th post-reset shift only; channels hold only the post-reset data.
